// File: rtl/half_adder.sv
// Bank of WIDTH independent half adders with a combinational result and an
// optional one-cycle registered copy qualified by a valid flag.
module half_adder #(
  parameter int unsigned WIDTH   = 1,
  parameter bit          REG_OUT = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] carry,
  output logic [WIDTH-1:0] sum,
  input  logic             in_valid,
  output logic [WIDTH-1:0] sum_q,
  output logic [WIDTH-1:0] carry_q,
  output logic             out_valid
);

  logic [WIDTH-1:0] w_sum;
  logic [WIDTH-1:0] w_carry;

  // Lanes are independent; no carry ever crosses a lane boundary.
  assign w_sum   = a ^ b;
  assign w_carry = a & b;
  assign sum     = w_sum;
  assign carry   = w_carry;

  generate
    if (REG_OUT) begin : g_reg
      logic [WIDTH-1:0] r_sum;
      logic [WIDTH-1:0] r_carry;
      logic             r_valid;

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          r_sum   <= '0;
          r_carry <= '0;
          r_valid <= 1'b0;
        end else begin
          r_valid <= in_valid;
          if (in_valid) begin
            r_sum   <= w_sum;
            r_carry <= w_carry;
          end
        end
      end

      assign sum_q     = r_sum;
      assign carry_q   = r_carry;
      assign out_valid = r_valid;
    end else begin : g_noreg
      logic w_unused;
      assign w_unused  = ^{clk, rst, in_valid};
      assign sum_q     = '0;
      assign carry_q   = '0;
      assign out_valid = 1'b0;
    end
  endgenerate

endmodule

// File: tb/tb_half_adder.sv
// Directed bench for half_adder: combinational truth table, multi-lane vectors,
// registered path with async reset, streaming, and the REG_OUT=0 tie-off.
module tb_half_adder;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic in_valid = 1'b0;
  logic iv_idle = 1'b0;

  logic       a1 = 1'b0, b1 = 1'b0;
  logic       s1, c1, sq1, cq1, ov1;
  logic [3:0] a4 = '0, b4 = '0;
  logic [3:0] s4, c4, sq4, cq4;
  logic       ov4;
  logic [7:0] a8 = '0, b8 = '0;
  logic [7:0] s8, c8, sq8, cq8;
  logic       ov8;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  half_adder #(.WIDTH(1), .REG_OUT(1'b1)) u_dut1 (
    .clk(clk), .rst(rst), .a(a1), .b(b1), .carry(c1), .sum(s1),
    .in_valid(in_valid), .sum_q(sq1), .carry_q(cq1), .out_valid(ov1)
  );

  half_adder #(.WIDTH(4), .REG_OUT(1'b0)) u_dut4 (
    .clk(clk), .rst(rst), .a(a4), .b(b4), .carry(c4), .sum(s4),
    .in_valid(in_valid), .sum_q(sq4), .carry_q(cq4), .out_valid(ov4)
  );

  half_adder #(.WIDTH(8), .REG_OUT(1'b1)) u_dut8 (
    .clk(clk), .rst(rst), .a(a8), .b(b8), .carry(c8), .sum(s8),
    .in_valid(iv_idle), .sum_q(sq8), .carry_q(cq8), .out_valid(ov8)
  );

  task automatic test_reset();
    @(negedge clk);
    rst = 1'b1;
    #1;
    n_vec++;
    if ({sq1, cq1, ov1} !== 3'b000) begin
      n_err++;
      $display("FAIL reset_regs: got sq/cq/ov=%b%b%b want 000", sq1, cq1, ov1);
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_comb_w1();
    logic [3:0] exp_s;
    logic [3:0] exp_c;
    logic [1:0] ab;
    exp_s = 4'b0110;
    exp_c = 4'b1000;
    for (int i = 0; i < 4; i++) begin
      ab = 2'(i);
      a1 = ab[1];
      b1 = ab[0];
      #10;
      n_vec++;
      if (s1 !== exp_s[i] || c1 !== exp_c[i]) begin
        n_err++;
        $display("FAIL comb_w1 ab=%b: got s/c=%b/%b want %b/%b", ab, s1, c1, exp_s[i], exp_c[i]);
      end
    end
  endtask

  task automatic test_comb_w4();
    a4 = 4'b1100;
    b4 = 4'b1010;
    #10;
    n_vec++;
    if (s4 !== 4'b0110 || c4 !== 4'b1000) begin
      n_err++;
      $display("FAIL comb_w4: got s=%b c=%b want s=0110 c=1000", s4, c4);
    end
  endtask

  task automatic test_registered();
    @(negedge clk);
    in_valid = 1'b1;
    a1 = 1'b1;
    b1 = 1'b1;
    @(posedge clk);
    #1;
    n_vec++;
    if ({sq1, cq1, ov1} !== 3'b011) begin
      n_err++;
      $display("FAIL reg_capture: got sq/cq/ov=%b%b%b want 011", sq1, cq1, ov1);
    end
    @(negedge clk);
    in_valid = 1'b0;
    a1 = 1'b1;
    b1 = 1'b0;
    @(posedge clk);
    #1;
    n_vec++;
    if ({sq1, cq1, ov1} !== 3'b010) begin
      n_err++;
      $display("FAIL reg_hold: got sq/cq/ov=%b%b%b want 010", sq1, cq1, ov1);
    end
  endtask

  task automatic test_async_reset();
    // Capture a nonzero result first so the reset has something to clear.
    @(negedge clk);
    in_valid = 1'b1;
    a1 = 1'b1;
    b1 = 1'b1;
    @(posedge clk);
    #1;
    a1 = 1'b0;
    b1 = 1'b1;
    rst = 1'b1;
    #1;
    n_vec++;
    if ({sq1, cq1, ov1} !== 3'b000) begin
      n_err++;
      $display("FAIL async_reset: got sq/cq/ov=%b%b%b want 000", sq1, cq1, ov1);
    end
    n_vec++;
    if (s1 !== 1'b1 || c1 !== 1'b0) begin
      n_err++;
      $display("FAIL comb_in_reset: got s/c=%b/%b want 1/0", s1, c1);
    end
    // in_valid is still high across this edge but reset dominates.
    @(posedge clk);
    #1;
    n_vec++;
    if ({sq1, cq1, ov1} !== 3'b000) begin
      n_err++;
      $display("FAIL reset_ignores_valid: got sq/cq/ov=%b%b%b want 000", sq1, cq1, ov1);
    end
    @(negedge clk);
    rst = 1'b0;
    a1 = 1'b1;
    b1 = 1'b0;
    @(posedge clk);
    #1;
    n_vec++;
    if ({sq1, cq1, ov1} !== 3'b101) begin
      n_err++;
      $display("FAIL first_after_release: got sq/cq/ov=%b%b%b want 101", sq1, cq1, ov1);
    end
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic test_back_to_back();
    logic [3:0] exp_s;
    logic [3:0] exp_c;
    logic [1:0] ab;
    exp_s = 4'b0110;
    exp_c = 4'b1000;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      ab = 2'(i);
      in_valid = 1'b1;
      a1 = ab[1];
      b1 = ab[0];
      @(posedge clk);
      #1;
      n_vec++;
      if (sq1 !== exp_s[i] || cq1 !== exp_c[i] || ov1 !== 1'b1) begin
        n_err++;
        $display("FAIL stream ab=%b: got sq/cq/ov=%b%b%b want %b%b1",
                 ab, sq1, cq1, ov1, exp_s[i], exp_c[i]);
      end
    end
    @(negedge clk);
    in_valid = 1'b0;
    @(posedge clk);
    #1;
    n_vec++;
    if ({sq1, cq1, ov1} !== 3'b010) begin
      n_err++;
      $display("FAIL stream_end: got sq/cq/ov=%b%b%b want 010", sq1, cq1, ov1);
    end
  endtask

  task automatic test_no_reg_out();
    @(negedge clk);
    in_valid = 1'b1;
    a4 = 4'b1111;
    b4 = 4'b1011;
    @(posedge clk);
    #1;
    n_vec++;
    if (sq4 !== 4'b0000 || cq4 !== 4'b0000 || ov4 !== 1'b0) begin
      n_err++;
      $display("FAIL no_reg_tieoff: got sq=%b cq=%b ov=%b want 0000 0000 0", sq4, cq4, ov4);
    end
    n_vec++;
    if (s4 !== 4'b0100 || c4 !== 4'b1011) begin
      n_err++;
      $display("FAIL comb_w4_b: got s=%b c=%b want s=0100 c=1011", s4, c4);
    end
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic test_random_w8();
    logic [7:0] es;
    logic [7:0] ec;
    for (int i = 0; i < 1000; i++) begin
      a8 = 8'($urandom);
      b8 = 8'($urandom);
      if (i == 0) begin a8 = 8'hFF; b8 = 8'hFF; end
      if (i == 1) begin a8 = 8'hAA; b8 = 8'h55; end
      es = a8 ^ b8;
      ec = a8 & b8;
      #1;
      n_vec++;
      if (s8 !== es || c8 !== ec || (s8 & c8) !== 8'h00) begin
        n_err++;
        $display("FAIL rand_w8 a=%h b=%h: got s=%h c=%h want s=%h c=%h", a8, b8, s8, c8, es, ec);
      end
    end
    n_vec++;
    if ({sq8, cq8, ov8} !== 17'd0) begin
      n_err++;
      $display("FAIL w8_idle_regs: got sq=%h cq=%h ov=%b want 0", sq8, cq8, ov8);
    end
  endtask

  initial begin
    test_comb_w1();
    test_comb_w4();
    test_reset();
    test_registered();
    test_async_reset();
    test_back_to_back();
    test_no_reg_out();
    test_random_w8();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
